seaquest_obs_serializer: RTL and testbench

Consumer-side bridge for the Seaquest `Compute_Single` step engine. It captures each completed step result on `i_valid`: the 736-bit observation, 32-bit reward and done flag. It then streams the result to the host DMA as a framed sequence of 32-bit words over a valid/ready stream. It replaces the simulation-only field dump with a synthesizable path, so the host unpacks the frame itself.

---
 rtl/seaquest_obs_serializer.sv | 182 ++++++++++++++++++
 tb/tb_seaquest_obs_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seaquest_obs_serializer.sv
// Captures one Seaquest step result and streams it to the host as a framed 32-bit word sequence.
// Optional trailing checksum word: define SEAQUEST_SER_CHECKSUM_EN.
module seaquest_obs_serializer #(
    parameter int unsigned OBS_WL = 736,
    parameter int unsigned RWD_WL = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [OBS_WL-1:0] i_obs,
    input  logic [RWD_WL-1:0] i_rwd,
    input  logic              i_done,
    output logic [31:0]       o_tdata,
    output logic              o_tvalid,
    output logic              o_tlast,
    input  logic              i_tready,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt,
    output logic [15:0]       o_drop_cnt
);

    localparam int unsigned OBS_WORDS = OBS_WL / 32;
`ifdef SEAQUEST_SER_CHECKSUM_EN
    localparam int unsigned LAST = OBS_WORDS + 2;
`else
    localparam int unsigned LAST = OBS_WORDS + 1;
`endif
    localparam int unsigned IDX_W = $clog2(LAST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
    localparam logic [IDX_W-1:0] OBS_IDX  = IDX_W'(OBS_WORDS);
    localparam logic [IDX_W-1:0] RWD_IDX  = IDX_W'(OBS_WORDS + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [OBS_WL-1:0]   obs_q, obs_d;
    logic [RWD_WL-1:0]   rwd_q, rwd_d;
    logic                done_q, done_d;
    logic [15:0]         seq_q, seq_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic [15:0]         dcnt_q, dcnt_d;
    logic [31:0]         tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
`ifdef SEAQUEST_SER_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    logic                hs;
    logic                last_hs;
    logic                accept;
    logic [31:0]         hdr_d;
    logic [31:0]         word_d;

    // Observation word k (1-based) counted from the MSB end.
    function automatic logic [31:0] obs_word(input logic [OBS_WL-1:0] obs, input logic [IDX_W-1:0] k);
        logic [OBS_WL-1:0] sh;
        sh = obs >> (32 * (OBS_WORDS - 32'(k)));
        return sh[31:0];
    endfunction

`ifdef SEAQUEST_SER_CHECKSUM_EN
    function automatic logic [31:0] obs_xor(input logic [OBS_WL-1:0] obs);
        logic [OBS_WL-1:0] t;
        logic [31:0]       x;
        t = obs;
        x = '0;
        for (int unsigned k = 0; k < OBS_WORDS; k++) begin
            x = x ^ t[31:0];
            t = t >> 32;
        end
        return x;
    endfunction
`endif

    always_comb begin
        hs      = tvalid_q && i_tready;
        last_hs = hs && (idx_q == LAST_IDX);
        accept  = i_valid && ((state_q == IDLE) || last_hs);

        state_d = state_q;
        idx_d   = idx_q;
        obs_d   = obs_q;
        rwd_d   = rwd_q;
        done_d  = done_q;
        seq_d   = seq_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
`ifdef SEAQUEST_SER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        if (accept) begin
            obs_d   = i_obs;
            rwd_d   = i_rwd;
            done_d  = i_done;
            seq_d   = fcnt_q;
            fcnt_d  = fcnt_q + 16'd1;
            idx_d   = '0;
            state_d = SEND;
`ifdef SEAQUEST_SER_CHECKSUM_EN
            csum_d  = {8'hA5, 7'd0, i_done, fcnt_q} ^ obs_xor(i_obs) ^ i_rwd;
`endif
        end else begin
            if (i_valid && (dcnt_q != '1)) begin
                dcnt_d = dcnt_q + 16'd1;
            end
            if (last_hs) begin
                state_d = IDLE;
                idx_d   = '0;
            end else if (hs) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Output registers are loaded from the next-state frame so a new header appears one cycle after accept.
        hdr_d = {8'hA5, 7'd0, done_d, seq_d};
        if (idx_d == '0) begin
            word_d = hdr_d;
        end else if (idx_d <= OBS_IDX) begin
            word_d = obs_word(obs_d, idx_d);
        end else if (idx_d == RWD_IDX) begin
            word_d = rwd_d;
        end else begin
`ifdef SEAQUEST_SER_CHECKSUM_EN
            word_d = csum_d;
`else
            word_d = '0;
`endif
        end

        tvalid_d = (state_d == SEND);
        tdata_d  = tvalid_d ? word_d : '0;
        tlast_d  = tvalid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            obs_q    <= '0;
            rwd_q    <= '0;
            done_q   <= 1'b0;
            seq_q    <= '0;
            fcnt_q   <= '0;
            dcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
`ifdef SEAQUEST_SER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            obs_q    <= obs_d;
            rwd_q    <= rwd_d;
            done_q   <= done_d;
            seq_q    <= seq_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
`ifdef SEAQUEST_SER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign o_tdata     = tdata_q;
    assign o_tvalid    = tvalid_q;
    assign o_tlast     = tlast_q;
    assign o_busy      = (state_q == SEND);
    assign o_frame_cnt = fcnt_q;
    assign o_drop_cnt  = dcnt_q;

endmodule

// File: tb/tb_seaquest_obs_serializer.sv
// Self-checking bench for seaquest_obs_serializer: table-driven frames plus drop, reset and back-to-back sequences.
module tb_seaquest_obs_serializer;

    localparam int unsigned OBS_WL = 736;
    localparam int unsigned OBS_WORDS = 23;
`ifdef SEAQUEST_SER_CHECKSUM_EN
    localparam int NW = 26;
`else
    localparam int NW = 25;
`endif

    logic              i_clk;
    logic              i_rstn;
    logic              i_valid;
    logic [OBS_WL-1:0] i_obs;
    logic [31:0]       i_rwd;
    logic              i_done;
    logic [31:0]       o_tdata;
    logic              o_tvalid;
    logic              o_tlast;
    logic              i_tready;
    logic              o_busy;
    logic [15:0]       o_frame_cnt;
    logic [15:0]       o_drop_cnt;

    seaquest_obs_serializer #(.OBS_WL(OBS_WL), .RWD_WL(32)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_valid     (i_valid),
        .i_obs       (i_obs),
        .i_rwd       (i_rwd),
        .i_done      (i_done),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .o_tlast     (o_tlast),
        .i_tready    (i_tready),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] rwd;
        logic        done;
        int          mode;
        logic [31:0] exp_hdr;
        logic [15:0] exp_fcnt;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[4];
    int          n_tests = 0;
    int          n_fail = 0;
    int          hs_frame = 0;
    int          mode = 0;
    int          cyc = 0;
    logic [15:0] m_seq = '0;
    logic [3:0]  pat = 4'b1001;
    logic        stall_pend = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OBS_WL-1:0] mk_obs(input logic [31:0] base, input logic [31:0] step);
        logic [OBS_WL-1:0] o;
        o = '0;
        for (int k = 1; k <= OBS_WORDS; k++) begin
            o = {o[OBS_WL-33:0], base + step * 32'(k)};
        end
        return o;
    endfunction

    task automatic push_frame(input logic [OBS_WL-1:0] obs, input logic [31:0] rwd, input logic done);
        logic [OBS_WL-1:0] t;
        logic [31:0]       w;
        logic [31:0]       x;
        exp_t              e;
        w = {8'hA5, 7'd0, done, m_seq};
        m_seq = m_seq + 16'd1;
        e.data = w; e.last = 1'b0; q.push_back(e);
        x = w;
        t = obs;
        for (int k = 0; k < OBS_WORDS; k++) begin
            w = t[OBS_WL-1 -: 32];
            t = t << 32;
            e.data = w; e.last = 1'b0; q.push_back(e);
            x = x ^ w;
        end
        e.data = rwd; e.last = (NW == 25); q.push_back(e);
        x = x ^ rwd;
`ifdef SEAQUEST_SER_CHECKSUM_EN
        e.data = x; e.last = 1'b1; q.push_back(e);
`endif
    endtask

    task automatic monitor();
        exp_t e;
        if (stall_pend) begin
            chk("stall_tvalid", {31'd0, o_tvalid}, 32'd1);
            chk("stall_tdata", o_tdata, stall_data);
            chk("stall_tlast", {31'd0, o_tlast}, {31'd0, stall_last});
        end
        if (o_tvalid && i_tready) begin
            hs_frame++;
            if (q.size() == 0) begin
                chk("unexpected_word", o_tdata, 32'hFFFF_FFFF);
                if (o_tdata == 32'hFFFF_FFFF) chk("unexpected_word_last", {31'd0, o_tlast}, 32'd2);
            end else begin
                e = q.pop_front();
                chk("word_data", o_tdata, e.data);
                chk("word_last", {31'd0, o_tlast}, {31'd0, e.last});
            end
        end
        stall_pend = o_tvalid && !i_tready;
        stall_data = o_tdata;
        stall_last = o_tlast;
    endtask

    task automatic tick();
        logic [1:0] ph;
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
        cyc++;
        ph = 2'(cyc);
        case (mode)
            1:       i_tready = pat[ph];
            2:       i_tready = 1'($urandom_range(0, 1));
            default: i_tready = 1'b1;
        endcase
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && q.size() != 0; c++) tick();
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic start_frame(input logic [OBS_WL-1:0] obs, input logic [31:0] rwd, input logic done);
        i_obs   = obs;
        i_rwd   = rwd;
        i_done  = done;
        i_valid = 1'b1;
        push_frame(obs, rwd, done);
        hs_frame = 0;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        for (int c = 0; c < 200 && hs_frame < n; c++) tick();
        if (hs_frame < n) chk("wait_hs_timeout", 32'(hs_frame), 32'(n));
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0001, 32'd10000,      1'b0, 0, 32'hA500_0000, 16'd1};
        vecs[1] = '{32'h1000_0000, 32'h0101_0101, 32'hDEAD_BEEF,  1'b1, 1, 32'hA501_0001, 16'd2};
        vecs[2] = '{32'hFFFF_FFF0, 32'h1357_9BDF, 32'h0000_0000,  1'b0, 2, 32'hA500_0002, 16'd3};
        vecs[3] = '{32'hCAFE_0000, 32'h0000_0007, 32'h8000_0001,  1'b1, 0, 32'hA501_0003, 16'd4};

        i_rstn = 1'b0; i_valid = 1'b0; i_obs = '0; i_rwd = '0; i_done = 1'b0; i_tready = 1'b1;
        repeat (3) tick();
        chk("rst_tdata", o_tdata, 32'd0);
        chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_fcnt", {16'd0, o_frame_cnt}, 32'd0);
        chk("rst_dcnt", {16'd0, o_drop_cnt}, 32'd0);
        i_rstn = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            start_frame(mk_obs(vecs[v].base, vecs[v].step), vecs[v].rwd, vecs[v].done);
            chk("hdr_latency_valid", {31'd0, o_tvalid}, 32'd1);
            chk("hdr_latency_data", o_tdata, vecs[v].exp_hdr);
            drain();
            chk("frame_handshakes", 32'(hs_frame), 32'(NW));
            chk("busy_after_frame", {31'd0, o_busy}, 32'd0);
            chk("frame_cnt", {16'd0, o_frame_cnt}, {16'd0, vecs[v].exp_fcnt});
            chk("drop_cnt_zero", {16'd0, o_drop_cnt}, 32'd0);
        end

        // Second result arrives mid-frame and must be dropped.
        mode = 0;
        start_frame(mk_obs(32'h0000_0055, 32'h3), 32'd1, 1'b0);
        wait_hs(5);
        i_obs = mk_obs(32'h7777_0000, 32'h11); i_rwd = 32'h1234_5678; i_done = 1'b1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        drain();
        chk("drop_cnt", {16'd0, o_drop_cnt}, 32'd1);
        chk("drop_fcnt", {16'd0, o_frame_cnt}, 32'd5);
        chk("drop_handshakes", 32'(hs_frame), 32'(NW));
        repeat (5) tick();
        chk("no_second_frame", {31'd0, o_tvalid}, 32'd0);
        chk("drop_busy", {31'd0, o_busy}, 32'd0);

        // Reset at word 10 abandons the frame; i_valid during reset is ignored.
        start_frame(mk_obs(32'hA0A0_0000, 32'h5), 32'h55AA_55AA, 1'b1);
        wait_hs(10);
        i_rstn = 1'b0; i_valid = 1'b1;
        tick();
        chk("midrst_tdata", o_tdata, 32'd0);
        chk("midrst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("midrst_tlast", {31'd0, o_tlast}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_fcnt", {16'd0, o_frame_cnt}, 32'd0);
        chk("midrst_dcnt", {16'd0, o_drop_cnt}, 32'd0);
        q.delete();
        m_seq = '0;
        stall_pend = 1'b0;
        i_rstn = 1'b1; i_valid = 1'b0;
        tick();
        chk("postrst_tvalid", {31'd0, o_tvalid}, 32'd0);

        // Back-to-back: next result arrives with the final-word handshake.
        start_frame(mk_obs(32'h0000_0000, 32'h1), 32'd10000, 1'b0);
        chk("b2b_hdr0", o_tdata, 32'hA500_0000);
        for (int c = 0; c < 100 && !(o_tvalid && o_tlast); c++) tick();
        chk("b2b_reach_last", {31'd0, o_tlast}, 32'd1);
        i_obs = mk_obs(32'h3C3C_0000, 32'h9); i_rwd = 32'hFEED_0001; i_done = 1'b1; i_valid = 1'b1;
        push_frame(i_obs, i_rwd, i_done);
        tick();
        i_valid = 1'b0;
        chk("b2b_no_gap", {31'd0, o_tvalid}, 32'd1);
        chk("b2b_hdr1", o_tdata, 32'hA501_0001);
        drain();
        chk("b2b_handshakes", 32'(hs_frame), 32'(2 * NW));
        chk("b2b_fcnt", {16'd0, o_frame_cnt}, 32'd2);
        chk("b2b_dcnt", {16'd0, o_drop_cnt}, 32'd0);
        chk("b2b_busy", {31'd0, o_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
